// File: rtl/arbiter4to1_if.sv
// Channel bundle between four input-side demuxes, the round-robin arbiter and the
// downstream router link. The slave modport is the arbiter's view.
interface arbiter4to1_if #(
    parameter int unsigned N = 32
);
    logic [3:0]        in_req;
    logic [3:0]        in_ack;
    logic [3:0][N-1:0] in_data;
    logic              out_req;
    logic              out_ack;
    logic [N-1:0]      out_data;
    logic [1:0]        grant;
    logic              busy;

    modport slave (
        input  in_req,
        input  in_data,
        input  out_ack,
        output in_ack,
        output out_req,
        output out_data,
        output grant,
        output busy
    );

    modport master (
        output in_req,
        output in_data,
        output out_ack,
        input  in_ack,
        input  out_req,
        input  out_data,
        input  grant,
        input  busy
    );
endinterface

// File: rtl/arbiter4to1.sv
// Round-robin arbiter sharing one four-phase output channel among four four-phase inputs.
// Requests and the downstream ack are synchronised; flit data is sampled only under a held req.
module arbiter4to1 #(
    parameter int unsigned N          = 32,
    parameter int unsigned SyncStages = 2
) (
    input logic          clk_i,
    input logic          rst_ni,
    arbiter4to1_if.slave bus_io
);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StRelease
    } state_e;

    logic [SyncStages-1:0][3:0] req_sync_q;
    logic [SyncStages-1:0]      ack_sync_q;
    logic [3:0]                 req_s;
    logic                       ack_s;

    state_e       state_q;
    logic [1:0]   ptr_q;
    logic [1:0]   grant_q;
    logic         out_req_q;
    logic [N-1:0] out_data_q;
    logic [3:0]   in_ack_q;
    logic         busy_q;

    logic [1:0]   win;
    logic [1:0]   cand;
    logic         found;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_sync_q <= '0;
            ack_sync_q <= '0;
        end else begin
            req_sync_q[0] <= bus_io.in_req;
            ack_sync_q[0] <= bus_io.out_ack;
            for (int unsigned s = 1; s < SyncStages; s++) begin
                req_sync_q[s] <= req_sync_q[s-1];
                ack_sync_q[s] <= ack_sync_q[s-1];
            end
        end
    end

    assign req_s = req_sync_q[SyncStages-1];
    assign ack_s = ack_sync_q[SyncStages-1];

    // Search ptr+1, ptr+2, ptr+3, ptr: the last served port has lowest priority.
    always_comb begin
        win   = ptr_q;
        cand  = ptr_q;
        found = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && req_s[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            ptr_q      <= 2'd3;
            grant_q    <= 2'd0;
            out_req_q  <= 1'b0;
            out_data_q <= '0;
            in_ack_q   <= 4'b0000;
            busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        out_data_q <= bus_io.in_data[win];
                        grant_q    <= win;
                        out_req_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    if (ack_s) begin
                        out_req_q <= 1'b0;
                        in_ack_q  <= 4'b0001 << grant_q;
                        state_q   <= StRelease;
                    end
                end
                StRelease: begin
                    // Both sides must finish their return-to-zero, in either order.
                    if (!req_s[grant_q] && !ack_s) begin
                        in_ack_q <= 4'b0000;
                        ptr_q    <= grant_q;
                        busy_q   <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: begin
                    out_req_q <= 1'b0;
                    in_ack_q  <= 4'b0000;
                    busy_q    <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    assign bus_io.in_ack   = in_ack_q;
    assign bus_io.out_req  = out_req_q;
    assign bus_io.out_data = out_data_q;
    assign bus_io.grant    = grant_q;
    assign bus_io.busy     = busy_q;

endmodule

// File: tb/tb_arbiter4to1.sv
// Bench for arbiter4to1: directed scenarios plus randomised request rounds checked against
// a round-robin model that picks winners from the set of pending ports.
module tb_arbiter4to1;
    localparam int unsigned N = 32;
    localparam int unsigned S = 2;
    localparam int          Budget = 200;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;
    int   ptr_m;
    logic [N-1:0] data_m [4];

    arbiter4to1_if #(.N(N)) bus ();

    arbiter4to1 #(.N(N), .SyncStages(S)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Never more than one acknowledge at a time, in any state.
    always @(negedge clk) begin
        if (rst_n) begin
            vectors++;
            if ($countones(bus.in_ack) > 1) begin
                errors++;
                $display("FAIL in_ack_onehot: in_ack=%b, required at most one bit set", bus.in_ack);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic int rr_pick(input int ptr, input logic [3:0] pend);
        for (int k = 1; k <= 4; k++) begin
            if (pend[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_req  = 4'b0000;
        bus.out_ack = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        ptr_m = 3;
    endtask

    task automatic wait_out_req(output int c, output bit ok);
        c = 0;
        while (!bus.out_req && c < Budget) begin
            tick();
            c++;
        end
        ok = bus.out_req;
    endtask

    task automatic wait_in_ack(output int c, output bit ok);
        c = 0;
        while (bus.in_ack == 4'b0000 && c < Budget) begin
            tick();
            c++;
        end
        ok = (bus.in_ack != 4'b0000);
    endtask

    task automatic wait_in_ack_low(output int c, output bit ok);
        c = 0;
        while (bus.in_ack != 4'b0000 && c < Budget) begin
            tick();
            c++;
        end
        ok = (bus.in_ack == 4'b0000);
    endtask

    // Sink and acknowledged source complete one transaction; src_lag < 0 drops out_ack first.
    task automatic serve_one(input int ack_delay, input int src_lag, output int g,
                             output logic [N-1:0] d, output bit ok);
        int c;
        bit o;
        int idx;
        ok = 1'b1;
        g = -1;
        d = '0;
        idx = 0;
        wait_out_req(c, o);
        if (!o) begin
            ok = 1'b0;
            return;
        end
        g = int'(bus.grant);
        d = bus.out_data;
        repeat (ack_delay) tick();
        bus.out_ack = 1'b1;
        wait_in_ack(c, o);
        if (!o) begin
            ok = 1'b0;
            bus.out_ack = 1'b0;
            return;
        end
        for (int i = 0; i < 4; i++) if (bus.in_ack[i]) idx = i;
        if (src_lag >= 0) begin
            bus.in_req[idx] = 1'b0;
            repeat (src_lag) tick();
            bus.out_ack = 1'b0;
        end else begin
            bus.out_ack = 1'b0;
            repeat (-src_lag) tick();
            bus.in_req[idx] = 1'b0;
        end
        wait_in_ack_low(c, o);
        if (!o) ok = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_req  = 4'b1111;
        bus.out_ack = 1'b0;
        for (int i = 0; i < 4; i++) bus.in_data[i] = $urandom;
        rst_n = 1'b0;
        tick();
        tick();
        tick();
        vectors++;
        if (bus.out_req !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: out_req=%b busy=%b, required 0 0", bus.out_req, bus.busy);
        end
        vectors++;
        if (bus.in_ack !== 4'b0000) begin
            errors++;
            $display("FAIL reset_in_ack: in_ack=%b, required 0000", bus.in_ack);
        end
        vectors++;
        if (bus.out_data !== '0 || bus.grant !== 2'd0) begin
            errors++;
            $display("FAIL reset_data: out_data=%h grant=%0d, required 0 0", bus.out_data, bus.grant);
        end
        bus.in_req = 4'b0000;
        rst_n = 1'b1;
        tick();
        ptr_m = 3;
    endtask

    task automatic test_single_flit();
        int c;
        bit o;
        bus.in_data[2] = 32'hA5A5_0001;
        bus.in_req[2]  = 1'b1;
        wait_out_req(c, o);
        vectors++;
        if (!o || c != S + 1) begin
            errors++;
            $display("FAIL single_req_latency: edges=%0d, required %0d", c, S + 1);
        end
        vectors++;
        if (bus.out_data !== 32'hA5A5_0001 || bus.grant !== 2'd2 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: out_data=%h grant=%0d busy=%b, required a5a50001 2 1",
                     bus.out_data, bus.grant, bus.busy);
        end
        tick();
        bus.out_ack = 1'b1;
        wait_in_ack(c, o);
        vectors++;
        if (!o || c != S + 1 || bus.in_ack !== 4'b0100 || bus.out_req !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: edges=%0d in_ack=%b out_req=%b, required %0d 0100 0",
                     c, bus.in_ack, bus.out_req, S + 1);
        end
        bus.in_req[2] = 1'b0;
        bus.out_ack   = 1'b0;
        wait_in_ack_low(c, o);
        vectors++;
        if (!o || c != S + 1 || bus.grant !== 2'd2 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release: edges=%0d grant=%0d busy=%b, required %0d 2 0",
                     c, bus.grant, bus.busy, S + 1);
        end
        ptr_m = 2;
    endtask

    task automatic test_all_four();
        logic [3:0] pend;
        int g;
        int exp_g;
        logic [N-1:0] d;
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            data_m[i] = $urandom;
            bus.in_data[i] = data_m[i];
        end
        pend = 4'b1111;
        bus.in_req = pend;
        for (int n = 0; n < 4; n++) begin
            exp_g = rr_pick(ptr_m, pend);
            serve_one(int'($urandom_range(0, 3)), 0, g, d, ok);
            vectors++;
            if (!ok || g != n || g != exp_g || d !== data_m[exp_g]) begin
                errors++;
                $display("FAIL all_four_order: grant=%0d data=%h ok=%b, required %0d %h",
                         g, d, ok, exp_g, data_m[exp_g]);
            end
            pend[exp_g] = 1'b0;
            ptr_m = exp_g;
        end
    endtask

    task automatic test_fairness();
        int seq_exp [4] = '{1, 3, 1, 3};
        logic [3:0] pend;
        int g;
        int exp_g;
        logic [N-1:0] d;
        bit ok;
        do_reset();
        data_m[1] = $urandom;
        data_m[3] = $urandom;
        bus.in_data[1] = data_m[1];
        bus.in_data[3] = data_m[3];
        pend = 4'b1010;
        bus.in_req = pend;
        for (int n = 0; n < 4; n++) begin
            exp_g = rr_pick(ptr_m, pend);
            serve_one(1, 0, g, d, ok);
            vectors++;
            if (!ok || g != seq_exp[n] || g != exp_g || d !== data_m[exp_g]) begin
                errors++;
                $display("FAIL fairness_seq%0d: grant=%0d data=%h ok=%b, required %0d %h",
                         n, g, d, ok, seq_exp[n], data_m[exp_g]);
            end
            ptr_m = exp_g;
            data_m[exp_g] = $urandom;
            bus.in_data[exp_g] = data_m[exp_g];
            bus.in_req[exp_g] = 1'b1;
        end
    endtask

    task automatic test_slow_sink();
        int c;
        bit o;
        do_reset();
        data_m[2] = $urandom;
        bus.in_data[2] = data_m[2];
        bus.in_req[2] = 1'b1;
        wait_out_req(c, o);
        vectors++;
        if (!o) begin
            errors++;
            $display("FAIL slow_sink_req: out_req=%b, required 1", bus.out_req);
        end
        for (int i = 0; i < 10; i++) begin
            bus.in_data[0] = $urandom;
            tick();
            vectors++;
            if (bus.out_data !== data_m[2] || bus.out_req !== 1'b1 || bus.in_ack !== 4'b0000) begin
                errors++;
                $display("FAIL slow_sink_hold%0d: out_data=%h out_req=%b in_ack=%b, required %h 1 0000",
                         i, bus.out_data, bus.out_req, bus.in_ack, data_m[2]);
            end
        end
        bus.out_ack = 1'b1;
        wait_in_ack(c, o);
        vectors++;
        if (!o || bus.in_ack !== 4'b0100 || bus.out_data !== data_m[2]) begin
            errors++;
            $display("FAIL slow_sink_ack: in_ack=%b out_data=%h, required 0100 %h",
                     bus.in_ack, bus.out_data, data_m[2]);
        end
        bus.in_req[2] = 1'b0;
        bus.out_ack = 1'b0;
        wait_in_ack_low(c, o);
        ptr_m = 2;
    endtask

    task automatic test_reset_in_release();
        int c;
        bit o;
        int g;
        logic [N-1:0] d;
        bit ok;
        do_reset();
        bus.in_data[1] = $urandom;
        bus.in_req[1] = 1'b1;
        wait_out_req(c, o);
        bus.out_ack = 1'b1;
        wait_in_ack(c, o);
        vectors++;
        if (!o || bus.in_ack !== 4'b0010) begin
            errors++;
            $display("FAIL rst_release_pre: in_ack=%b, required 0010", bus.in_ack);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.in_ack !== 4'b0000 || bus.out_req !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_release_async: in_ack=%b out_req=%b busy=%b, required 0000 0 0",
                     bus.in_ack, bus.out_req, bus.busy);
        end
        bus.in_req = 4'b0000;
        bus.out_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        ptr_m = 3;
        data_m[0] = $urandom;
        data_m[2] = $urandom;
        bus.in_data[0] = data_m[0];
        bus.in_data[2] = data_m[2];
        bus.in_req = 4'b0101;
        serve_one(0, 0, g, d, ok);
        vectors++;
        if (!ok || g != 0 || d !== data_m[0]) begin
            errors++;
            $display("FAIL rst_release_first: grant=%0d data=%h, required 0 %h", g, d, data_m[0]);
        end
        serve_one(2, 1, g, d, ok);
        vectors++;
        if (!ok || g != 2 || d !== data_m[2]) begin
            errors++;
            $display("FAIL rst_release_second: grant=%0d data=%h, required 2 %h", g, d, data_m[2]);
        end
        ptr_m = 2;
    endtask

    task automatic test_out_of_order();
        int c;
        bit o;
        do_reset();
        bus.in_data[3] = $urandom;
        bus.in_req[3] = 1'b1;
        wait_out_req(c, o);
        bus.out_ack = 1'b1;
        wait_in_ack(c, o);
        bus.in_req[3] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (bus.in_ack !== 4'b1000) begin
                errors++;
                $display("FAIL ooo_hold%0d: in_ack=%b, required 1000", i, bus.in_ack);
            end
        end
        bus.out_ack = 1'b0;
        wait_in_ack_low(c, o);
        vectors++;
        if (!o || c != S + 1) begin
            errors++;
            $display("FAIL ooo_release: edges=%0d, required %0d", c, S + 1);
        end
        ptr_m = 3;
    endtask

    task automatic test_random();
        do_reset();
        for (int r = 0; r < 12; r++) begin
            logic [3:0] pend;
            int g;
            int exp_g;
            logic [N-1:0] d;
            bit ok;
            pend = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                if (pend[i]) begin
                    data_m[i] = $urandom;
                    bus.in_data[i] = data_m[i];
                end
            end
            bus.in_req = pend;
            while (pend != 4'b0000) begin
                exp_g = rr_pick(ptr_m, pend);
                serve_one(int'($urandom_range(0, 4)), int'($urandom_range(0, 6)) - 3, g, d, ok);
                vectors++;
                if (!ok || g != exp_g || d !== data_m[exp_g]) begin
                    errors++;
                    $display("FAIL random_r%0d: grant=%0d data=%h ok=%b, required %0d %h",
                             r, g, d, ok, exp_g, data_m[exp_g]);
                    if (!ok) begin
                        do_reset();
                        return;
                    end
                end
                pend[exp_g] = 1'b0;
                ptr_m = exp_g;
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors = 0;
        ptr_m = 3;
        rst_n = 1'b0;
        bus.in_req = 4'b0000;
        bus.out_ack = 1'b0;
        for (int i = 0; i < 4; i++) bus.in_data[i] = '0;
        test_reset();
        test_single_flit();
        test_all_four();
        test_fairness();
        test_slow_sink();
        test_reset_in_release();
        test_out_of_order();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
